// File: rtl/taylor_out_bank_pkg.sv
// Shared widths for the float-core output path; the processor wrapper imports the same values.
package taylor_out_bank_pkg;

  localparam int unsigned TaylorNbits = 28;
  localparam int unsigned TaylorNch   = 4;
  localparam int unsigned TaylorCw    = $clog2(TaylorNch);
  localparam int unsigned TaylorDepth = 8;

  // True when more than one bit of a strobe vector is set.
  function automatic logic is_multi_hot(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/taylor_out_bank_if.sv
// Valid/ready stream carrying the FIFO head (result word plus its port index).
interface taylor_out_bank_if
  import taylor_out_bank_pkg::*;
#(
  parameter int unsigned NBITS = TaylorNbits,
  parameter int unsigned CW    = TaylorCw
);

  logic signed [NBITS-1:0] m_data;
  logic [CW-1:0]           m_chan;
  logic                    m_valid;
  logic                    m_ready;

  modport master (output m_data, output m_chan, output m_valid, input m_ready);
  modport slave  (input m_data, input m_chan, input m_valid, output m_ready);

endinterface

// File: rtl/taylor_fifo.sv
// First-word-fall-through FIFO; count distinguishes full from empty, pointers wrap mod DEPTH.
module taylor_fifo
  import taylor_out_bank_pkg::*;
#(
  parameter int unsigned WIDTH = TaylorNbits + TaylorCw,
  parameter int unsigned DEPTH = TaylorDepth,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CntW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ok,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  // Handshake decode; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    rd_valid = count_q != '0;
    pop      = rd_ready && rd_valid;
    wr_ok    = (count_q != CntW'(DEPTH)) || pop;
    push     = wr_en && wr_ok;
    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until the matching pointer makes them visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/taylor_out_bank.sv
// Collects processor results per port and queues them, port-tagged, for a downstream consumer.
module taylor_out_bank
  import taylor_out_bank_pkg::*;
#(
  parameter int unsigned NBITS = TaylorNbits,
  parameter int unsigned NCH   = TaylorNch,
  parameter int unsigned DEPTH = TaylorDepth,
  localparam int unsigned CW   = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [NBITS-1:0] io_out,
  input  logic [NCH-1:0]          out_en,
  input  logic                    clr,
  taylor_out_bank_if.master       m_if,
  output logic [NCH*NBITS-1:0]    hold,
  output logic [NCH-1:0]          hold_vld,
  output logic                    ovf,
  output logic                    multi,
  output logic [$clog2(DEPTH):0]  count
);

  logic [CW-1:0]        sel;
  logic                 capture, drop, fifo_wr_ok;
  logic [CW+NBITS-1:0]  fifo_rd_data;
  logic [NCH*NBITS-1:0] hold_q, hold_d;
  logic [NCH-1:0]       hold_vld_q, hold_vld_d;
  logic                 ovf_q, ovf_d;
  logic                 multi_q, multi_d;

  // Priority encoder: scanning downwards lets the lowest set bit win.
  always_comb begin
    sel = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (out_en[k]) sel = CW'(k);
    end
    capture = |out_en;
    drop    = capture && !fifo_wr_ok;
  end

  taylor_fifo #(
    .WIDTH (CW + NBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (capture),
    .wr_data  ({sel, io_out}),
    .wr_ok    (fifo_wr_ok),
    .rd_ready (m_if.m_ready),
    .rd_data  (fifo_rd_data),
    .rd_valid (m_if.m_valid),
    .count    (count)
  );

  assign m_if.m_data = fifo_rd_data[NBITS-1:0];
  assign m_if.m_chan = fifo_rd_data[NBITS +: CW];

  // Holding registers update even on a dropped FIFO write; a new error beats clr.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    ovf_d      = clr ? 1'b0 : ovf_q;
    multi_d    = clr ? 1'b0 : multi_q;
    if (capture) begin
      hold_d[sel*NBITS +: NBITS] = io_out;
      hold_vld_d[sel]            = 1'b1;
      if (is_multi_hot(32'(out_en))) multi_d = 1'b1;
    end
    if (drop) ovf_d = 1'b1;
  end

  // Holding registers and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= '0;
      ovf_q      <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ovf_q      <= ovf_d;
      multi_q    <= multi_d;
    end
  end

  assign hold     = hold_q;
  assign hold_vld = hold_vld_q;
  assign ovf      = ovf_q;
  assign multi    = multi_q;

endmodule

// File: tb/tb_taylor_out_bank.sv
// Scoreboard bench for taylor_out_bank: expected entries queued at capture, checked at pop.
module tb_taylor_out_bank;
  import taylor_out_bank_pkg::*;

  localparam int unsigned NBITS = TaylorNbits;
  localparam int unsigned NCH   = TaylorNch;
  localparam int unsigned DEPTH = TaylorDepth;
  localparam int unsigned CW    = TaylorCw;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [NBITS-1:0] io_out;
  logic [NCH-1:0]          out_en;
  logic                    clr;
  logic [NCH*NBITS-1:0]    hold;
  logic [NCH-1:0]          hold_vld;
  logic                    ovf, multi;
  logic [$clog2(DEPTH):0]  count;

  taylor_out_bank_if #(.NBITS(NBITS), .CW(CW)) m_if ();

  taylor_out_bank #(
    .NBITS (NBITS),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_out   (io_out),
    .out_en   (out_en),
    .clr      (clr),
    .m_if     (m_if),
    .hold     (hold),
    .hold_vld (hold_vld),
    .ovf      (ovf),
    .multi    (multi),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW+NBITS-1:0] sb [$];
  logic [NBITS-1:0]    exp_hold [NCH];
  logic [NCH-1:0]      exp_hold_vld;
  logic                exp_ovf, exp_multi;
  logic                stall_q;
  logic [NBITS-1:0]    stall_data;
  logic [CW-1:0]       stall_chan;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < NCH; i++) exp_hold[i] = '0;
    exp_hold_vld = '0;
    exp_ovf      = 1'b0;
    exp_multi    = 1'b0;
    stall_q      = 1'b0;
  endtask

  // Compares every visible output against the model state after the last edge.
  task automatic check_state();
    logic [NCH*NBITS-1:0] h;
    for (int i = 0; i < NCH; i++) h[i*NBITS +: NBITS] = exp_hold[i];
    check_eq("count", 128'(count), 128'(sb.size()));
    check_eq("m_valid", 128'(m_if.m_valid), 128'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq("m_data", 128'($unsigned(m_if.m_data)), 128'(sb[0][NBITS-1:0]));
      check_eq("m_chan", 128'(m_if.m_chan), 128'(sb[0][NBITS +: CW]));
    end
    check_eq("hold", 128'(hold), 128'(h));
    check_eq("hold_vld", 128'(hold_vld), 128'(exp_hold_vld));
    check_eq("ovf", 128'(ovf), 128'(exp_ovf));
    check_eq("multi", 128'(multi), 128'(exp_multi));
  endtask

  // One clock: drive inputs, check current outputs, advance the model, cross the edge.
  task automatic cycle(input logic [NCH-1:0] en, input int val, input logic rdy, input logic c);
    logic [NBITS-1:0] d;
    int               k;
    d             = NBITS'(val);
    out_en        = en;
    io_out        = d;
    m_if.m_ready  = rdy;
    clr           = c;
    #2;
    check_state();
    if (stall_q) begin
      check_eq("stall_data", 128'($unsigned(m_if.m_data)), 128'(stall_data));
      check_eq("stall_chan", 128'(m_if.m_chan), 128'(stall_chan));
    end
    stall_q    = m_if.m_valid && !rdy;
    stall_data = m_if.m_data;
    stall_chan = m_if.m_chan;
    if (rdy && sb.size() != 0) void'(sb.pop_front());
    if (c) begin
      exp_ovf   = 1'b0;
      exp_multi = 1'b0;
    end
    if (en != '0) begin
      k = 0;
      for (int i = NCH - 1; i >= 0; i--) if (en[i]) k = i;
      exp_hold[k]     = d;
      exp_hold_vld[k] = 1'b1;
      if ((en & (en - 1'b1)) != '0) exp_multi = 1'b1;
      if (sb.size() < DEPTH) sb.push_back({CW'(k), d});
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_valid"}, 128'(m_if.m_valid), 128'(0));
    check_eq({tag, "_m_data"}, 128'($unsigned(m_if.m_data)), 128'(0));
    check_eq({tag, "_m_chan"}, 128'(m_if.m_chan), 128'(0));
    check_eq({tag, "_hold"}, 128'(hold), 128'(0));
    check_eq({tag, "_hold_vld"}, 128'(hold_vld), 128'(0));
    check_eq({tag, "_ovf"}, 128'(ovf), 128'(0));
    check_eq({tag, "_multi"}, 128'(multi), 128'(0));
    check_eq({tag, "_count"}, 128'(count), 128'(0));
  endtask

  initial begin
    rst          = 1'b1;
    out_en       = '0;
    io_out       = '0;
    clr          = 1'b0;
    m_if.m_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single capture on port 2.
    cycle(4'b0100, -5, 1'b0, 1'b0);
    check_eq("single_m_data", 128'($unsigned(m_if.m_data)), 128'(28'hffffffb));
    check_eq("single_m_chan", 128'(m_if.m_chan), 128'(2));
    check_eq("single_count", 128'(count), 128'(1));
    cycle('0, 0, 1'b1, 1'b0);
    cycle('0, 0, 1'b0, 1'b0);

    // Fill and overflow on port 0.
    for (int v = 1; v <= 9; v++) cycle(4'b0001, v, 1'b0, 1'b0);
    check_eq("fill_count", 128'(count), 128'(8));
    check_eq("fill_ovf", 128'(ovf), 128'(1));
    check_eq("fill_hold0", 128'(hold[NBITS-1:0]), 128'(9));
    for (int i = 0; i < DEPTH + 1; i++) cycle('0, 0, 1'b1, 1'b0);
    cycle('0, 0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int v = 11; v <= 18; v++) cycle(4'b0001, v, 1'b0, 1'b0);
    cycle(4'b1000, 100, 1'b1, 1'b0);
    check_eq("fullpp_count", 128'(count), 128'(8));
    check_eq("fullpp_ovf", 128'(ovf), 128'(0));
    for (int i = 0; i < DEPTH + 1; i++) cycle('0, 0, 1'b1, 1'b0);

    // Multi-hot enable, clr alone, then clr racing a new multi-hot event.
    cycle(4'b1010, 7, 1'b0, 1'b0);
    check_eq("multi_chan", 128'(m_if.m_chan), 128'(1));
    check_eq("multi_flag", 128'(multi), 128'(1));
    cycle('0, 0, 1'b1, 1'b0);
    cycle('0, 0, 1'b0, 1'b1);
    check_eq("multi_clr", 128'(multi), 128'(0));
    cycle(4'b0011, 8, 1'b0, 1'b1);
    check_eq("multi_race", 128'(multi), 128'(1));
    cycle('0, 0, 1'b1, 1'b0);
    cycle('0, 0, 1'b0, 1'b1);

    // Back-pressure with random ready.
    cycle(4'b0001, 21, 1'b0, 1'b0);
    cycle(4'b0100, -22, 1'b0, 1'b0);
    cycle(4'b1000, 23, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cycle('0, 0, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 4; i++) cycle('0, 0, 1'b1, 1'b0);

    // Mid-stream asynchronous reset with five entries queued.
    for (int v = 31; v <= 35; v++) cycle(4'b0010, v, 1'b0, 1'b0);
    check_eq("pre_rst_count", 128'(count), 128'(5));
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    #1 rst = 1'b0;
    cycle(4'b0100, -5, 1'b0, 1'b0);
    check_eq("post_rst_m_data", 128'($unsigned(m_if.m_data)), 128'(28'hffffffb));
    check_eq("post_rst_m_chan", 128'(m_if.m_chan), 128'(2));
    check_eq("post_rst_hold_vld", 128'(hold_vld), 128'(4'b0100));
    cycle('0, 0, 1'b1, 1'b0);
    cycle('0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
